// File: rtl/id_ex_skid_pkg.sv
// Shared decode/execute definitions for the ID/EX skid register.
// Bus widths and NOP encodings live here so parameter defaults track the core.
package id_ex_skid_pkg;

    localparam int unsigned AluOpBus   = 8;
    localparam int unsigned AluSelBus  = 3;
    localparam int unsigned RegBus     = 32;
    localparam int unsigned RegAddrBus = 5;

    localparam logic [AluOpBus-1:0]   EXE_NOP_OP   = 8'h00;
    localparam logic [AluSelBus-1:0]  EXE_RES_NOP  = 3'b000;
    localparam logic [RegBus-1:0]     ZeroWord     = 32'h0000_0000;
    localparam logic [RegAddrBus-1:0] NOPRegAddr   = 5'b00000;
    localparam logic                  WriteDisable = 1'b0;
    localparam logic                  RstEnable    = 1'b1;

    // Packed payload width: aluop, alusel, reg1, reg2, wd, wreg, dslot.
    function automatic int unsigned payload_width(input int unsigned aluop_w,
                                                  input int unsigned alusel_w,
                                                  input int unsigned reg_w,
                                                  input int unsigned regaddr_w);
        return aluop_w + alusel_w + 2 * reg_w + regaddr_w + 2;
    endfunction

endpackage

// File: rtl/id_ex_skid_skid_entry.sv
// One storage slot of the ID/EX skid buffer: payload register plus valid bit.
// Clearing (reset or squash) forces the payload to CLR_VAL so an empty slot
// always carries a harmless encoding.
module skid_entry
    import id_ex_skid_pkg::*;
#(
    parameter int unsigned  W       = 8,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] data,
    output logic         valid
);

    // Slot register: clear wins over load, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || clr) begin
            valid <= 1'b0;
            data  <= CLR_VAL;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/id_ex_skid.sv
// Elastic decode-to-execute register with a 2-entry skid buffer.
// The main slot drives ex_* directly; the skid slot absorbs one instruction
// when execute stalls, so id_ready is registered and never depends on ex_ready.
// Optional performance counters are enabled with ID_EX_SKID_PERF_EN.
module id_ex_skid
    import id_ex_skid_pkg::*;
#(
    parameter int unsigned          ALUOP_W    = AluOpBus,
    parameter int unsigned          ALUSEL_W   = AluSelBus,
    parameter int unsigned          REG_W      = RegBus,
    parameter int unsigned          REGADDR_W  = RegAddrBus,
    parameter logic [ALUOP_W-1:0]   NOP_ALUOP  = EXE_NOP_OP,
    parameter logic [ALUSEL_W-1:0]  NOP_ALUSEL = EXE_RES_NOP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [ALUOP_W-1:0]   id_aluop,
    input  logic [ALUSEL_W-1:0]  id_alusel,
    input  logic [REG_W-1:0]     id_reg1,
    input  logic [REG_W-1:0]     id_reg2,
    input  logic [REGADDR_W-1:0] id_wd,
    input  logic                 id_wreg,
    input  logic                 id_dslot,
    output logic                 ex_valid,
    input  logic                 ex_ready,
`ifdef ID_EX_SKID_PERF_EN
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_bubble_cnt,
`endif
    output logic [ALUOP_W-1:0]   ex_aluop,
    output logic [ALUSEL_W-1:0]  ex_alusel,
    output logic [REG_W-1:0]     ex_reg1,
    output logic [REG_W-1:0]     ex_reg2,
    output logic [REGADDR_W-1:0] ex_wd,
    output logic                 ex_wreg,
    output logic                 ex_dslot
);

    localparam int unsigned PW = payload_width(ALUOP_W, ALUSEL_W, REG_W, REGADDR_W);

    // Bubble encoding: NOP op, no register write, not a delay slot.
    localparam logic [PW-1:0] NOP_PAYLOAD = {NOP_ALUOP, NOP_ALUSEL, {REG_W{1'b0}},
                                             {REG_W{1'b0}}, {REGADDR_W{1'b0}},
                                             WriteDisable, 1'b0};

    logic [PW-1:0] id_payload;
    logic [PW-1:0] main_data;
    logic [PW-1:0] skid_data;
    logic [PW-1:0] main_load_data;
    logic          main_valid;
    logic          skid_valid;
    logic          main_load;
    logic          main_clr;
    logic          skid_load;
    logic          skid_clr;
    logic          skid_valid_d;
    logic          ready_q;
    logic          xfer_in;
    logic          xfer_out;

    assign id_payload = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg, id_dslot};
    assign xfer_in    = id_valid & ready_q;
    assign xfer_out   = main_valid & ex_ready;

    // Slot control: decide loads/clears for both entries; flush overrides everything.
    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        main_load_data = id_payload;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (!main_valid) begin
            // Skid is never occupied while main is empty.
            main_load = xfer_in;
        end else if (xfer_out) begin
            if (skid_valid) begin
                // id_ready was low, so nothing can arrive this cycle.
                main_load      = 1'b1;
                main_load_data = skid_data;
                skid_clr       = 1'b1;
            end else if (xfer_in) begin
                main_load = 1'b1;
            end else begin
                main_clr = 1'b1;
            end
        end else begin
            skid_load = xfer_in;
        end
    end

    // Next skid occupancy, used to register id_ready.
    always_comb begin
        skid_valid_d = skid_valid;
        if (skid_clr) begin
            skid_valid_d = 1'b0;
        end else if (skid_load) begin
            skid_valid_d = 1'b1;
        end
    end

    // Ready register: high whenever the skid slot will be free.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= ~skid_valid_d;
        end
    end

    assign id_ready = ready_q;

    skid_entry #(
        .W       (PW),
        .CLR_VAL (NOP_PAYLOAD)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .clr       (main_clr),
        .load      (main_load),
        .load_data (main_load_data),
        .data      (main_data),
        .valid     (main_valid)
    );

    skid_entry #(
        .W       (PW),
        .CLR_VAL (NOP_PAYLOAD)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clr       (skid_clr),
        .load      (skid_load),
        .load_data (id_payload),
        .data      (skid_data),
        .valid     (skid_valid)
    );

    assign ex_valid = main_valid;
    assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_dslot} = main_data;

`ifdef ID_EX_SKID_PERF_EN
    // Saturating stall/bubble counters; flush does not clear them.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            perf_stall_cnt  <= 32'd0;
            perf_bubble_cnt <= 32'd0;
        end else begin
            if (main_valid && !ex_ready && perf_stall_cnt != 32'hFFFF_FFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (!main_valid && perf_bubble_cnt != 32'hFFFF_FFFF) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
// Self-checking bench for id_ex_skid: a scoreboard queue models the held
// entries; directed sequences cover reset, streaming, back-pressure, flush,
// delay slot and (with ID_EX_SKID_PERF_EN) the performance counters.
module tb_id_ex_skid;

    localparam int PW = 82;
    localparam logic [PW-1:0] NOP_PL = '0;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [7:0]  id_aluop;
    logic [2:0]  id_alusel;
    logic [31:0] id_reg1;
    logic [31:0] id_reg2;
    logic [4:0]  id_wd;
    logic        id_wreg;
    logic        id_dslot;
    logic        ex_valid;
    logic        ex_ready;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg1;
    logic [31:0] ex_reg2;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic        ex_dslot;
`ifdef ID_EX_SKID_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    logic [PW-1:0] ex_pl;
    logic [PW-1:0] id_pl;
    logic [PW-1:0] sb_q[$];
    bit            mon_en = 1'b0;
    int            n_checks = 0;
    int            n_errors = 0;

    assign ex_pl = {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_dslot};
    assign id_pl = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg, id_dslot};

    always #5 clk = ~clk;

    id_ex_skid dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_aluop        (id_aluop),
        .id_alusel       (id_alusel),
        .id_reg1         (id_reg1),
        .id_reg2         (id_reg2),
        .id_wd           (id_wd),
        .id_wreg         (id_wreg),
        .id_dslot        (id_dslot),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
`ifdef ID_EX_SKID_PERF_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt),
`endif
        .ex_aluop        (ex_aluop),
        .ex_alusel       (ex_alusel),
        .ex_reg1         (ex_reg1),
        .ex_reg2         (ex_reg2),
        .ex_wd           (ex_wd),
        .ex_wreg         (ex_wreg),
        .ex_dslot        (ex_dslot)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input logic [7:0] op, input logic [2:0] sel,
                                         input logic [31:0] r1, input logic [31:0] r2,
                                         input logic [4:0] wd, input logic wreg,
                                         input logic dslot);
        return {op, sel, r1, r2, wd, wreg, dslot};
    endfunction

    task automatic drive(input logic [PW-1:0] p);
        {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg, id_dslot} = p;
        id_valid = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hold the offered instruction until a handshake edge, bounded.
    task automatic wait_accept(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ok = id_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        id_valid = 1'b0;
        check(tag, ok, 1);
    endtask

    // Scoreboard: queue size is the expected occupancy, front is the expected ex_* payload.
    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_ex_valid", ex_valid, sb_q.size() > 0);
            check("mon_id_ready", id_ready, sb_q.size() < 2);
            if (sb_q.size() > 0) check("mon_ex_payload", ex_pl, sb_q[0]);
            else                 check("mon_nop_payload", ex_pl, NOP_PL);
            if (rst || flush) begin
                sb_q.delete();
            end else begin
                if (ex_valid && ex_ready && sb_q.size() > 0) void'(sb_q.pop_front());
                if (id_valid && id_ready) sb_q.push_back(id_pl);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] pa;
        logic [PW-1:0] pb;
        logic [PW-1:0] pc;
        logic [31:0]   s0;
        logic [31:0]   b0;

        rst      = 1'b1;
        flush    = 1'b0;
        ex_ready = 1'b0;
        drive(mk(8'h5A, 3'b111, 32'h1234, 32'h5678, 5'd7, 1'b1, 1'b1));

        // Reset with id_valid high: nothing captured.
        tick;
        mon_en = 1'b1;
        tick;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_aluop", ex_aluop, 8'h00);
        check("rst_ex_wreg", ex_wreg, 0);
        rst      = 1'b0;
        id_valid = 1'b0;
        tick;
        check("rst_id_ready", id_ready, 1);
        check("rst_still_empty", ex_valid, 0);

        // Streaming: one-cycle latency, no back-pressure.
        ex_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(mk(8'h21, 3'b001, i, $urandom, 5'(i), 1'b1, 1'b0));
            tick;
            check("stream_reg1", ex_reg1, i);
            check("stream_id_ready", id_ready, 1);
        end
        id_valid = 1'b0;
        tick;
        check("stream_drained", ex_valid, 0);

        // Back-pressure: A in main, B in skid, C held by decode.
        ex_ready = 1'b0;
        pa = mk(8'h11, 3'b010, 32'hA, $urandom, 5'd1, 1'b1, 1'b0);
        pb = mk(8'h12, 3'b011, 32'hB, $urandom, 5'd2, 1'b1, 1'b0);
        pc = mk(8'h13, 3'b100, 32'hC, $urandom, 5'd3, 1'b0, 1'b0);
        drive(pa);
        wait_accept("bp_accept_a");
        drive(pb);
        wait_accept("bp_accept_b");
        check("bp_full_ready", id_ready, 0);
        check("bp_hold_a", ex_reg1, 32'hA);
        drive(pc);
        tick;
        tick;
        check("bp_still_a", ex_reg1, 32'hA);
        check("bp_still_full", id_ready, 0);
        ex_ready = 1'b1;
        wait_accept("bp_accept_c");
        for (int i = 0; i < 10; i++) begin
            if (!ex_valid) break;
            tick;
        end
        check("bp_drained", ex_valid, 0);
        check("bp_sb_empty", sb_q.size(), 0);

        // Flush with both entries full and a new instruction offered.
        ex_ready = 1'b0;
        drive(mk(8'h44, 3'b001, 32'hDEAD, 32'h1, 5'd4, 1'b1, 1'b0));
        wait_accept("fl_accept_x");
        drive(mk(8'h45, 3'b001, 32'hBEEF, 32'h2, 5'd5, 1'b1, 1'b0));
        wait_accept("fl_accept_y");
        check("fl_full", id_ready, 0);
        drive(mk(8'h46, 3'b001, 32'hCAFE, 32'h3, 5'd6, 1'b1, 1'b0));
        flush = 1'b1;
        tick;
        flush    = 1'b0;
        id_valid = 1'b0;
        check("fl_ex_valid", ex_valid, 0);
        check("fl_ex_wreg", ex_wreg, 0);
        check("fl_id_ready", id_ready, 1);
        ex_ready = 1'b1;
        repeat (3) tick;
        check("fl_no_ghost", ex_valid, 0);

        // Delay slot instruction, then a bubble.
        ex_ready = 1'b0;
        drive(mk(8'h33, 3'b100, 32'h5, 32'h6, 5'd31, 1'b1, 1'b1));
        wait_accept("ds_accept");
        check("ds_dslot", ex_dslot, 1);
        check("ds_wd", ex_wd, 5'd31);
        check("ds_wreg", ex_wreg, 1);
        ex_ready = 1'b1;
        tick;
        check("ds_bubble_valid", ex_valid, 0);
        check("ds_bubble_dslot", ex_dslot, 0);

`ifdef ID_EX_SKID_PERF_EN
        // Three stall cycles, then two empty cycles, then a flush.
        ex_ready = 1'b0;
        drive(mk(8'h77, 3'b010, 32'h77, 32'h0, 5'd9, 1'b1, 1'b0));
        wait_accept("perf_accept");
        s0 = perf_stall_cnt;
        repeat (3) tick;
        check("perf_stall3", perf_stall_cnt - s0, 3);
        ex_ready = 1'b1;
        tick;
        b0 = perf_bubble_cnt;
        repeat (2) tick;
        check("perf_bubble2", perf_bubble_cnt - b0, 2);
        s0 = perf_stall_cnt;
        b0 = perf_bubble_cnt;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("perf_flush_stall", perf_stall_cnt, s0);
        check("perf_flush_bubble", perf_bubble_cnt, b0 + 32'd1);
`else
        s0 = 32'd0;
        b0 = 32'd0;
`endif

        tick;
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
